// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard controller: FSM states and the
// per-stage enable/flush encodings used for the IF/ID .. MEM/WB registers.
package pipe_pkg;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      MEMWAIT = 2'd1,
      HALT    = 2'd2
   } state_t;

   typedef struct packed {
      logic enable;
      logic flush;
   } stageCtrl_t;

   localparam stageCtrl_t STG_PASS   = '{enable: 1'b1, flush: 1'b0};
   localparam stageCtrl_t STG_BUBBLE = '{enable: 1'b1, flush: 1'b1};
   localparam stageCtrl_t STG_HOLD   = '{enable: 1'b0, flush: 1'b0};
   // Frozen pipeline still drains a bubble into WB so no instruction retires twice.
   localparam stageCtrl_t STG_DRAIN  = '{enable: 1'b0, flush: 1'b1};
   localparam stageCtrl_t STG_OFF    = '{enable: 1'b0, flush: 1'b0};

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare: a load in ID/EX writing a register that the
// instruction in IF/ID reads. Register $zero never creates a hazard.
module hazard_detect (
   input  logic [4:0] idRs,
   input  logic [4:0] idRt,
   input  logic       exMemRead,
   input  logic [4:0] exRegDest,
   output logic       loadUse
);

   always_comb begin
      loadUse = exMemRead && (exRegDest != 5'd0) &&
                ((exRegDest == idRs) || (exRegDest == idRt));
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, MEM-stage
// branch/jump squash, data-memory wait handling with timeout, stall counter.
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 16,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [4:0]       idRs,
   input  logic [4:0]       idRt,
   input  logic             exMemRead,
   input  logic [4:0]       exRegDest,
   input  logic             memMemRead,
   input  logic             memMemWrite,
   input  logic             memBranchTaken,
   input  logic             memJump,
   input  logic             dmemReady,
   output logic             dmemReq,
   output logic             pcEnable,
   output logic             ifidEnable,
   output logic             idexEnable,
   output logic             exmemEnable,
   output logic             memwbEnable,
   output logic             ifidFlush,
   output logic             idexFlush,
   output logic             exmemFlush,
   output logic             memwbFlush,
   output logic             pcSel,
   output logic             memTimeout,
   output logic [CNT_W-1:0] stallCycles
);

   localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

   state_t            state, stateNext;
   logic [WAIT_W-1:0] waitCnt, waitNext;
   logic              timeoutNext;
   logic              loadUse;
   logic              memAcc;
   logic              normalRules;
   logic              freeze;
   stageCtrl_t        ifidCtrl, idexCtrl, exmemCtrl, memwbCtrl;

   hazard_detect uHazard (
      .idRs      (idRs),
      .idRt      (idRt),
      .exMemRead (exMemRead),
      .exRegDest (exRegDest),
      .loadUse   (loadUse)
   );

   always_comb begin
      memAcc      = memMemRead | memMemWrite;
      stateNext   = state;
      waitNext    = waitCnt;
      timeoutNext = memTimeout;
      normalRules = 1'b0;
      freeze      = 1'b0;
      dmemReq     = 1'b0;

      unique case (state)
         RUN: begin
            dmemReq = memAcc;
            if (memAcc && !dmemReady) begin
               freeze    = 1'b1;
               stateNext = MEMWAIT;
               waitNext  = WAIT_W'(1);
            end else begin
               normalRules = 1'b1;
            end
         end
         MEMWAIT: begin
            dmemReq = memAcc;
            if (!dmemReady) begin
               freeze = 1'b1;
               if (waitCnt == WAIT_W'(MAX_WAIT)) begin
                  stateNext   = HALT;
                  timeoutNext = 1'b1;
               end else begin
                  waitNext = waitCnt + WAIT_W'(1);
               end
            end else begin
               normalRules = 1'b1;
               stateNext   = RUN;
            end
         end
         HALT: begin
            freeze = 1'b1;
         end
         default: begin
            freeze    = 1'b1;
            stateNext = RUN;
         end
      endcase

      pcEnable  = 1'b1;
      pcSel     = 1'b0;
      ifidCtrl  = STG_PASS;
      idexCtrl  = STG_PASS;
      exmemCtrl = STG_PASS;
      memwbCtrl = STG_PASS;

      if (freeze) begin
         pcEnable  = 1'b0;
         ifidCtrl  = STG_HOLD;
         idexCtrl  = STG_HOLD;
         exmemCtrl = STG_HOLD;
         memwbCtrl = STG_DRAIN;
      end else if (normalRules) begin
         // Redirect wins over load-use: the stalled instruction is squashed anyway.
         if (memBranchTaken || memJump) begin
            pcSel     = 1'b1;
            ifidCtrl  = STG_BUBBLE;
            idexCtrl  = STG_BUBBLE;
            exmemCtrl = STG_BUBBLE;
         end else if (loadUse) begin
            pcEnable = 1'b0;
            ifidCtrl = STG_HOLD;
            idexCtrl = STG_BUBBLE;
         end
      end

      if (reset) begin
         dmemReq   = 1'b0;
         pcEnable  = 1'b0;
         pcSel     = 1'b0;
         ifidCtrl  = STG_OFF;
         idexCtrl  = STG_OFF;
         exmemCtrl = STG_OFF;
         memwbCtrl = STG_OFF;
      end

      ifidEnable  = ifidCtrl.enable;
      ifidFlush   = ifidCtrl.flush;
      idexEnable  = idexCtrl.enable;
      idexFlush   = idexCtrl.flush;
      exmemEnable = exmemCtrl.enable;
      exmemFlush  = exmemCtrl.flush;
      memwbEnable = memwbCtrl.enable;
      memwbFlush  = memwbCtrl.flush;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= RUN;
         waitCnt     <= '0;
         memTimeout  <= 1'b0;
         stallCycles <= '0;
      end else begin
         state      <= stateNext;
         waitCnt    <= waitNext;
         memTimeout <= timeoutNext;
         if (!pcEnable) begin
            stallCycles <= stallCycles + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl with MAX_WAIT=4.
module tb_pipe_hazard_ctrl;

   logic        clock = 1'b0;
   logic        reset;
   logic [4:0]  idRs, idRt, exRegDest;
   logic        exMemRead, memMemRead, memMemWrite, memBranchTaken, memJump, dmemReady;
   logic        dmemReq, pcEnable, ifidEnable, idexEnable, exmemEnable, memwbEnable;
   logic        ifidFlush, idexFlush, exmemFlush, memwbFlush, pcSel, memTimeout;
   logic [31:0] stallCycles;

   int nVec = 0;
   int nMis = 0;

   // {pc,ifid,idex,exmem,memwb enables | ifid,idex,exmem,memwb flushes | pcSel | dmemReq}
   localparam logic [10:0] O_ZERO    = 11'b00000_0000_0_0;
   localparam logic [10:0] O_NORMAL  = 11'b11111_0000_0_0;
   localparam logic [10:0] O_NORMREQ = 11'b11111_0000_0_1;
   localparam logic [10:0] O_LOADUSE = 11'b00111_0100_0_0;
   localparam logic [10:0] O_BRANCH  = 11'b11111_1110_1_0;
   localparam logic [10:0] O_BRREQ   = 11'b11111_1110_1_1;
   localparam logic [10:0] O_FREEZE  = 11'b00000_0001_0_1;
   localparam logic [10:0] O_HALT    = 11'b00000_0001_0_0;

   logic [10:0] outs;
   assign outs = {pcEnable, ifidEnable, idexEnable, exmemEnable, memwbEnable,
                  ifidFlush, idexFlush, exmemFlush, memwbFlush, pcSel, dmemReq};

   pipe_hazard_ctrl #(.MAX_WAIT(4), .CNT_W(32)) dut (
      .clock          (clock),
      .reset          (reset),
      .idRs           (idRs),
      .idRt           (idRt),
      .exMemRead      (exMemRead),
      .exRegDest      (exRegDest),
      .memMemRead     (memMemRead),
      .memMemWrite    (memMemWrite),
      .memBranchTaken (memBranchTaken),
      .memJump        (memJump),
      .dmemReady      (dmemReady),
      .dmemReq        (dmemReq),
      .pcEnable       (pcEnable),
      .ifidEnable     (ifidEnable),
      .idexEnable     (idexEnable),
      .exmemEnable    (exmemEnable),
      .memwbEnable    (memwbEnable),
      .ifidFlush      (ifidFlush),
      .idexFlush      (idexFlush),
      .exmemFlush     (exmemFlush),
      .memwbFlush     (memwbFlush),
      .pcSel          (pcSel),
      .memTimeout     (memTimeout),
      .stallCycles    (stallCycles)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nVec++;
      assert (obs === exp) else begin
         nMis++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      idRs = 5'd0; idRt = 5'd0; exRegDest = 5'd0; exMemRead = 1'b0;
      memMemRead = 1'b0; memMemWrite = 1'b0; memBranchTaken = 1'b0;
      memJump = 1'b0; dmemReady = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      idle();

      // reset state
      @(negedge clock); #1;
      check("rst_outs", 32'(outs), 32'(O_ZERO));
      check("rst_stall", stallCycles, 32'd0);
      check("rst_timeout", 32'(memTimeout), 32'd0);

      @(negedge clock); reset = 1'b0; #1;
      check("run_idle", 32'(outs), 32'(O_NORMAL));

      // load-use on rs: lw $t1 in ID/EX, add reads $t1
      @(negedge clock); exMemRead = 1'b1; exRegDest = 5'd9; idRs = 5'd9; idRt = 5'd10; #1;
      check("lu_rs", 32'(outs), 32'(O_LOADUSE));
      check("lu_stall_before", stallCycles, 32'd0);
      @(negedge clock); exMemRead = 1'b0; exRegDest = 5'd0; #1;
      check("lu_bubble_passed", 32'(outs), 32'(O_NORMAL));
      check("lu_stall_after", stallCycles, 32'd1);

      // load-use on rt
      @(negedge clock); exMemRead = 1'b1; exRegDest = 5'd10; idRs = 5'd0; idRt = 5'd10; #1;
      check("lu_rt", 32'(outs), 32'(O_LOADUSE));

      // $zero destination never stalls
      @(negedge clock); exRegDest = 5'd0; idRs = 5'd0; idRt = 5'd0; #1;
      check("lu_zero_reg", 32'(outs), 32'(O_NORMAL));
      check("lu_rt_stall", stallCycles, 32'd2);
      @(negedge clock); exRegDest = 5'd5; idRs = 5'd6; idRt = 5'd7; #1;
      check("lu_nomatch", 32'(outs), 32'(O_NORMAL));
      @(negedge clock); exMemRead = 1'b0; exRegDest = 5'd6; idRs = 5'd6; #1;
      check("lu_not_load", 32'(outs), 32'(O_NORMAL));

      // branch/jump override a load-use condition
      @(negedge clock); exMemRead = 1'b1; exRegDest = 5'd9; idRs = 5'd9; memBranchTaken = 1'b1; #1;
      check("br_over_lu", 32'(outs), 32'(O_BRANCH));
      @(negedge clock); memBranchTaken = 1'b0; memJump = 1'b1; #1;
      check("jmp_over_lu", 32'(outs), 32'(O_BRANCH));
      @(negedge clock); idle(); #1;
      check("br_no_stall", stallCycles, 32'd2);

      // slow memory, ready after 3 wait cycles (fresh counter)
      reset = 1'b1; #1; reset = 1'b0; #1;
      check("slow_stall0", stallCycles, 32'd0);
      @(negedge clock); memMemRead = 1'b1; #1;
      check("slow_c1", 32'(outs), 32'(O_FREEZE));
      @(negedge clock); #1;
      check("slow_c2", 32'(outs), 32'(O_FREEZE));
      @(negedge clock); #1;
      check("slow_c3", 32'(outs), 32'(O_FREEZE));
      @(negedge clock); dmemReady = 1'b1; #1;
      check("slow_c4_done", 32'(outs), 32'(O_NORMREQ));
      check("slow_stall3", stallCycles, 32'd3);
      @(negedge clock); idle(); #1;
      check("slow_after", 32'(outs), 32'(O_NORMAL));
      check("slow_stall_hold", stallCycles, 32'd3);

      // branch held during a memory wait is taken only on completion
      @(negedge clock); memMemWrite = 1'b1; memBranchTaken = 1'b1; #1;
      check("brwait_frozen", 32'(outs), 32'(O_FREEZE));
      @(negedge clock); dmemReady = 1'b1; #1;
      check("brwait_complete", 32'(outs), 32'(O_BRREQ));
      check("brwait_stall", stallCycles, 32'd4);

      // access ready in its first cycle costs nothing
      @(negedge clock); idle(); memMemRead = 1'b1; dmemReady = 1'b1; #1;
      check("fast_mem", 32'(outs), 32'(O_NORMREQ));
      @(negedge clock); idle(); #1;
      check("fast_mem_stall", stallCycles, 32'd4);

      // async reset during MEMWAIT cycle 2
      @(negedge clock); memMemRead = 1'b1; #1;
      check("rstw_c1", 32'(outs), 32'(O_FREEZE));
      @(negedge clock); #1;
      check("rstw_c2", 32'(outs), 32'(O_FREEZE));
      #1 reset = 1'b1; #1;
      check("rstw_outs", 32'(outs), 32'(O_ZERO));
      check("rstw_stall", stallCycles, 32'd0);
      check("rstw_timeout", 32'(memTimeout), 32'd0);
      #1 reset = 1'b0; memMemRead = 1'b0; #1;
      check("rstw_run", 32'(outs), 32'(O_NORMAL));

      // timeout: RUN stall cycle then 4 MEMWAIT cycles, then HALT
      @(negedge clock); memMemRead = 1'b1; #1;
      check("to_c1", 32'(outs), 32'(O_FREEZE));
      @(negedge clock); #1;
      @(negedge clock); #1;
      @(negedge clock); #1;
      @(negedge clock); #1;
      check("to_c5", 32'(outs), 32'(O_FREEZE));
      check("to_not_yet", 32'(memTimeout), 32'd0);
      @(negedge clock); #1;
      check("to_flag", 32'(memTimeout), 32'd1);
      check("to_halt", 32'(outs), 32'(O_HALT));
      check("to_stall5", stallCycles, 32'd5);
      @(negedge clock); memMemRead = 1'b0; dmemReady = 1'b1; #1;
      check("halt_sticky", 32'(outs), 32'(O_HALT));
      @(negedge clock); #1;
      check("halt_stall7", stallCycles, 32'd7);
      check("halt_flag", 32'(memTimeout), 32'd1);

      // only reset leaves HALT
      @(negedge clock); reset = 1'b1; #1;
      check("halt_rst_outs", 32'(outs), 32'(O_ZERO));
      check("halt_rst_flag", 32'(memTimeout), 32'd0);
      check("halt_rst_stall", stallCycles, 32'd0);
      @(negedge clock); reset = 1'b0; idle(); #1;
      check("post_rst_run", 32'(outs), 32'(O_NORMAL));
      @(negedge clock); #1;
      check("post_rst_stall", stallCycles, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
      $finish;
   end

endmodule
